// File: rtl/instruction_sequencer.sv
`timescale 1ns/1ps
// Front end for the combinational controller: an instruction FIFO feeding the
// instruction register, plus the 2-bit timestep counter and retire bookkeeping.
module instruction_sequencer #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  input  logic [WIDTH-1:0]         InstrIn,
  input  logic                     InstrValid,
  output logic                     InstrReady,
  input  logic                     ResetTimestepReq,
  input  logic                     Stall,
  input  logic                     Flush,
  output logic [WIDTH-1:0]         InstrReg,
  output logic [1:0]               Timestep,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(DEPTH):0]   Occupancy,
  output logic [15:0]              RetiredCount
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic {IDLE, EXEC} state_t;
  state_t state;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             has_entry, retire, push, pop;

  assign has_entry  = (Occupancy != '0);
  assign InstrReady = !Flush && (Occupancy < FULL);
  assign push       = InstrValid && InstrReady;
  assign retire     = (state == EXEC) && !Stall && !Flush &&
                      (ResetTimestepReq || Timestep == 2'd3);
  // A pop is always paired with an IR load: either leaving IDLE or chaining on retire.
  assign pop        = !Flush && has_entry && ((state == IDLE) || retire);

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= InstrIn;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      Occupancy <= '0;
    end else if (Flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      Occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   Occupancy <= Occupancy + ONE;
        2'b01:   Occupancy <= Occupancy - ONE;
        default: Occupancy <= Occupancy;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state        <= IDLE;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Timestep     <= 2'd0;
      InstrReg     <= '0;
      RetiredCount <= 16'd0;
    end else begin
      Done <= 1'b0;
      if (Flush) begin
        state    <= IDLE;
        Busy     <= 1'b0;
        Timestep <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (has_entry) begin
              InstrReg <= mem[rd_ptr];
              Timestep <= 2'd0;
              state    <= EXEC;
              Busy     <= 1'b1;
            end
          end
          EXEC: begin
            if (retire) begin
              Done         <= 1'b1;
              RetiredCount <= RetiredCount + 16'd1;
              Timestep     <= 2'd0;
              if (has_entry) begin
                InstrReg <= mem[rd_ptr];
              end else begin
                state <= IDLE;
                Busy  <= 1'b0;
              end
            end else if (!Stall) begin
              Timestep <= Timestep + 2'd1;
            end
          end
          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
